// File: rtl/weight_init_sequencer.sv
// Loads signed weights into the weight RAM one layer bank at a time from a valid/ready stream,
// and withholds the RAM from the compute engine until loading completes. Optional: WINIT_CHECKSUM_EN.
module weight_init_sequencer #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH0 = 16,
    parameter int unsigned DEPTH1 = 16,
    parameter int unsigned DEPTH2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic [1:0]        layer,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W+1:0] count,
    input  logic              compute_req,
`ifdef WINIT_CHECKSUM_EN
    output logic              compute_gnt,
    output logic [15:0]       checksum
`else
    output logic              compute_gnt
`endif
);

    localparam int unsigned CNT_W  = ADDR_W + 2;
    localparam int unsigned CSUM_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_NEXT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(DEPTH0 - 1);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(DEPTH1 - 1);
    localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(DEPTH2 - 1);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [ADDR_W-1:0] wcnt;
    logic [ADDR_W-1:0] cur_last_c;
    logic              accept_c;
    logic              final_c;
    logic              idle_or_done_c;

    // Last address of the bank currently being filled
    always_comb begin
        cur_last_c = LAST2;
        case (layer)
            2'd0:    cur_last_c = LAST0;
            2'd1:    cur_last_c = LAST1;
            default: cur_last_c = LAST2;
        endcase
    end

    assign accept_c       = in_ready & in_valid;
    assign final_c        = accept_c && (wcnt == cur_last_c);
    assign idle_or_done_c = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (final_c) begin
                    next_state = (layer == 2'd2) ? S_DONE : S_NEXT;
                end
            end
            S_NEXT:  next_state = S_LOAD;
            default: next_state = S_IDLE;
        endcase
    end

    // Status flags track the state being entered so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            compute_gnt <= 1'b0;
        end else begin
            in_ready    <= (next_state == S_LOAD);
            busy        <= (next_state == S_LOAD) || (next_state == S_NEXT);
            done        <= (next_state == S_DONE);
            compute_gnt <= idle_or_done_c && !start && compute_req;
        end
    end

    // Write port, per-layer address counter and running word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            wcnt  <= '0;
            layer <= 2'd0;
            count <= '0;
        end else begin
            we <= accept_c;
            if (idle_or_done_c && start) begin
                wcnt  <= '0;
                layer <= 2'd0;
                count <= '0;
            end
            if (accept_c) begin
                wdata <= in_data;
                addr  <= wcnt;
                count <= count + CNT_W'(1);
                wcnt  <= final_c ? '0 : wcnt + ADDR_W'(1);
            end
            // Bank switch waits until the last write of the old bank has been presented
            if (state == S_NEXT) begin
                layer <= layer + 2'd1;
            end
        end
    end

`ifdef WINIT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (idle_or_done_c && start) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= checksum + CSUM_W'($signed(in_data));
        end
    end
`endif

endmodule
